// File: rtl/pattern_blinker.sv
// Multi-channel blink-pattern sequencer: each channel plays a STEPS-long on/off
// pattern, one step per TICK_DIV clocks, with one-shot or looping playback.
module pattern_blinker #(
  parameter int CHANNELS = 1,
  parameter int STEPS    = 27,
  parameter int TICK_DIV = 50_000_000,
  parameter logic [CHANNELS*STEPS-1:0] PATTERN = 27'h7F0FC3F
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  output logic [CHANNELS-1:0]   out,
  output logic                  busy,
  output logic                  done,
  output logic [((STEPS > 1) ? $clog2(STEPS) : 1)-1:0] step_idx
);

  localparam int unsigned SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IW = $clog2(CHANNELS * STEPS);
  localparam logic [SW-1:0] LAST_S = SW'(STEPS - 1);
  localparam logic [PW-1:0] LAST_P = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q;
  logic [PW-1:0]         presc_q;
  logic [SW-1:0]         step_q;
  logic [CHANNELS-1:0]   out_q;
  logic                  busy_q;
  logic                  done_q;
  logic [SW-1:0]         step_nxt_d;
  logic [CHANNELS-1:0]   bits_nxt_d;
  logic [CHANNELS-1:0]   bits_first_d;

  function automatic logic [CHANNELS-1:0] step_bits(input logic [SW-1:0] idx);
    logic [CHANNELS-1:0] bits;
    logic [IW-1:0]       pos;
    bits = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      pos     = IW'(c * STEPS) + IW'(idx);
      bits[c] = PATTERN[pos];
    end
    return bits;
  endfunction

  // Next step wraps to 0 after the last one; only used when looping.
  always_comb begin
    step_nxt_d   = (step_q == LAST_S) ? '0 : step_q + SW'(1);
    bits_nxt_d   = step_bits(step_nxt_d);
    bits_first_d = step_bits('0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      step_q  <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          presc_q <= '0;
          step_q  <= '0;
          out_q   <= '0;
          busy_q  <= 1'b0;
          if (start && !stop) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            out_q   <= bits_first_d;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            presc_q <= '0;
            step_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
          end else if (presc_q == LAST_P) begin
            presc_q <= '0;
            if (step_q == LAST_S && !loop_en) begin
              state_q <= IDLE;
              step_q  <= '0;
              out_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              step_q <= step_nxt_d;
              out_q  <= bits_nxt_d;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = step_q;

endmodule

// File: tb/tb_pattern_blinker.sv
// Bench for pattern_blinker: a 2-channel/8-step/div-4 instance and a default
// 27-step instance with TICK_DIV=1 share one stimulus and an elapsed-time model.
module tb_pattern_blinker;

  localparam logic [15:0] PAT_A = 16'hF0A5;
  localparam logic [26:0] PAT_B = 27'h7F0FC3F;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, loop_en;
  logic [1:0] out_a;
  logic       busy_a, done_a;
  logic [2:0] step_a;
  logic [0:0] out_b;
  logic       busy_b, done_b;
  logic [4:0] step_b;

  int errors = 0;
  int checks = 0;
  int e = 0;

  always #5 clk = ~clk;

  pattern_blinker #(.CHANNELS(2), .STEPS(8), .TICK_DIV(4), .PATTERN(PAT_A)) dut_a (
    .clk(clk), .reset(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .out(out_a), .busy(busy_a), .done(done_a), .step_idx(step_a)
  );

  pattern_blinker #(.TICK_DIV(1)) dut_b (
    .clk(clk), .reset(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .out(out_b), .busy(busy_b), .done(done_b), .step_idx(step_b)
  );

  // Model: elapsed cycles since start; step = elapsed / tick.
  logic ra, da, rb, db;
  int   ta, tb;

  function automatic void mstep(input int steps, input int tick, input logic st,
                                input logic sp, input logic le, inout logic run,
                                inout int t, inout logic dn);
    dn = 1'b0;
    if (!run) begin
      if (st && !sp) begin
        run = 1'b1;
        t   = 0;
      end
    end else if (sp) begin
      run = 1'b0;
    end else begin
      t = t + 1;
      if (t == steps * tick) begin
        if (le) t = 0;
        else begin
          run = 1'b0;
          dn  = 1'b1;
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ra = 1'b0; da = 1'b0; ta = 0;
      rb = 1'b0; db = 1'b0; tb = 0;
    end else begin
      mstep(8, 4, start, stop, loop_en, ra, ta, da);
      mstep(27, 1, start, stop, loop_en, rb, tb, db);
    end
  end

  function automatic logic [1:0] exp_out_a(input logic r, input int t);
    if (!r) return 2'b00;
    return {PAT_A[8 + t / 4], PAT_A[t / 4]};
  endfunction

  function automatic logic exp_out_b(input logic r, input int t);
    if (!r) return 1'b0;
    return PAT_B[t];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_out", 32'(out_a), 32'(exp_out_a(ra, ta)));
    chk("a_busy", 32'(busy_a), 32'(ra));
    chk("a_done", 32'(done_a), 32'(da));
    chk("a_step", 32'(step_a), ra ? 32'(ta / 4) : 32'd0);
    chk("b_out", 32'(out_b), 32'(exp_out_b(rb, tb)));
    chk("b_busy", 32'(busy_b), 32'(rb));
    chk("b_done", 32'(done_b), 32'(db));
    chk("b_step", 32'(step_b), rb ? 32'(tb) : 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    e = 0;
  endtask

  task automatic adv_to(input int n);
    while (e < n) begin
      tick();
      e++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    #1;
    chk("rst_out_a", 32'(out_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_step_a", 32'(step_a), 0);
    idle(2);
    rst = 1'b0;
    idle(2);

    // one-shot
    go();
    chk("s1_out_e0", 32'(out_a), 32'h1);
    chk("s1_busy_e0", 32'(busy_a), 1);
    adv_to(4);  chk("s1_out_e4", 32'(out_a), 32'h0);
    adv_to(5);  chk("s1_b_out_e5", 32'(out_b), 1);
    adv_to(6);  chk("s1_b_out_e6", 32'(out_b), 0);
    adv_to(8);  chk("s1_out_e8", 32'(out_a), 32'h1);
    adv_to(16); chk("s1_out_e16", 32'(out_a), 32'h2);
    adv_to(27); chk("s1_b_done_e27", 32'(done_b), 1);
    adv_to(28); chk("s1_out_e28", 32'(out_a), 32'h3);
    adv_to(31); chk("s1_busy_e31", 32'(busy_a), 1);
    adv_to(32);
    chk("s1_done_e32", 32'(done_a), 1);
    chk("s1_busy_e32", 32'(busy_a), 0);
    chk("s1_out_e32", 32'(out_a), 0);
    adv_to(33); chk("s1_done_e33", 32'(done_a), 0);

    // looping, then stop
    idle(3);
    loop_en = 1'b1;
    go();
    adv_to(31); chk("s2_step_e31", 32'(step_a), 7);
    adv_to(32);
    chk("s2_step_e32", 32'(step_a), 0);
    chk("s2_out_e32", 32'(out_a), 32'h1);
    chk("s2_busy_e32", 32'(busy_a), 1);
    chk("s2_done_e32", 32'(done_a), 0);
    adv_to(40);
    stop = 1'b1;
    adv_to(41);
    stop = 1'b0;
    chk("s2_busy_e41", 32'(busy_a), 0);
    chk("s2_out_e41", 32'(out_a), 0);
    chk("s2_done_e41", 32'(done_a), 0);
    loop_en = 1'b0;

    // start while running is ignored
    idle(3);
    go();
    adv_to(4);  start = 1'b1;
    adv_to(5);  start = 1'b0;
    adv_to(16); start = 1'b1;
    adv_to(17); start = 1'b0;
    adv_to(31); chk("s3_step_e31", 32'(step_a), 7);
    adv_to(32); chk("s3_done_e32", 32'(done_a), 1);

    // start+stop together in idle; stop at end of last step
    idle(3);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("s4_both_busy_a", 32'(busy_a), 0);
    chk("s4_both_busy_b", 32'(busy_b), 0);
    go();
    adv_to(31); stop = 1'b1;
    adv_to(32); stop = 1'b0;
    chk("s4_stop_busy", 32'(busy_a), 0);
    chk("s4_stop_done", 32'(done_a), 0);
    adv_to(33); chk("s4_stop_done_e33", 32'(done_a), 0);

    // asynchronous reset in step 3
    idle(3);
    go();
    adv_to(13);
    chk("s5_step_pre", 32'(step_a), 3);
    #2 rst = 1'b1;
    #1;
    chk("s5_rst_out", 32'(out_a), 0);
    chk("s5_rst_busy", 32'(busy_a), 0);
    chk("s5_rst_step", 32'(step_a), 0);
    chk("s5_rst_done", 32'(done_a), 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    go();
    chk("s5_replay_out", 32'(out_a), 32'h1);
    chk("s5_replay_step", 32'(step_a), 0);
    adv_to(32); chk("s5_replay_done", 32'(done_a), 1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
